// File: rtl/led_blink_driver.sv
// Indicator driver: converts a one-cycle request pulse into a burst of
// fixed-length blinks on a registered output, with cancel and optional restart.
module led_blink_driver #(
  parameter int ON_CYCLES  = 4,
  parameter int OFF_CYCLES = 4,
  parameter int COUNT_W    = 4,
  parameter int RETRIGGER  = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               trigger,
  input  logic [COUNT_W-1:0] blink_count,
  input  logic               cancel,
  output logic               led_out,
  output logic               busy,
  output logic               done
);

  localparam int MAX_CYCLES = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
  localparam int TIMER_W    = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    OFF  = 2'd2
  } state_t;

  state_t               state, state_nxt;
  logic [TIMER_W-1:0]   timer, timer_nxt;
  logic [COUNT_W-1:0]   remaining, remaining_nxt;
  logic                 done_nxt;
  logic                 start;

  // A start is accepted from IDLE, or from a running sequence only when restart is enabled.
  assign start = trigger && (blink_count != '0) && ((state == IDLE) || (RETRIGGER != 0));

  always_comb begin
    state_nxt     = state;
    timer_nxt     = timer;
    remaining_nxt = remaining;
    done_nxt      = 1'b0;
    if (cancel) begin
      if (state != IDLE) begin
        state_nxt     = IDLE;
        timer_nxt     = '0;
        remaining_nxt = '0;
      end
    end else if (start) begin
      state_nxt     = ON;
      timer_nxt     = TIMER_W'(ON_CYCLES - 1);
      remaining_nxt = blink_count;
    end else begin
      case (state)
        ON: begin
          if (timer != '0) begin
            timer_nxt = timer - TIMER_W'(1);
          end else if (remaining == COUNT_W'(1)) begin
            state_nxt     = IDLE;
            remaining_nxt = '0;
            done_nxt      = 1'b1;
          end else begin
            state_nxt     = OFF;
            timer_nxt     = TIMER_W'(OFF_CYCLES - 1);
            remaining_nxt = remaining - COUNT_W'(1);
          end
        end
        OFF: begin
          if (timer != '0) begin
            timer_nxt = timer - TIMER_W'(1);
          end else begin
            state_nxt = ON;
            timer_nxt = TIMER_W'(ON_CYCLES - 1);
          end
        end
        default: begin
          state_nxt = IDLE;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state so they change on the same edge as the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      timer     <= '0;
      remaining <= '0;
      led_out   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_nxt;
      timer     <= timer_nxt;
      remaining <= remaining_nxt;
      led_out   <= (state_nxt == ON);
      busy      <= (state_nxt != IDLE);
      done      <= done_nxt;
    end
  end

endmodule

// File: tb/tb_led_blink_driver.sv
// Directed bench for led_blink_driver: one instance without restart, one with,
// expected {led_out,busy,done} per cycle queued at stimulus time and checked after each edge.
module tb_led_blink_driver;

  localparam int ON_C    = 3;
  localparam int OFF_C   = 2;
  localparam int COUNT_W = 4;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               trigger = 1'b0;
  logic [COUNT_W-1:0] blink_count = '0;
  logic               cancel = 1'b0;
  logic               en1 = 1'b1;
  logic               trigger1, cancel1;
  logic               led0, busy0, done0;
  logic               led1, busy1, done1;

  assign trigger1 = trigger & en1;
  assign cancel1  = cancel & en1;

  led_blink_driver #(.ON_CYCLES(ON_C), .OFF_CYCLES(OFF_C), .COUNT_W(COUNT_W), .RETRIGGER(0)) dut0 (
    .clk(clk), .rst(rst), .trigger(trigger), .blink_count(blink_count), .cancel(cancel),
    .led_out(led0), .busy(busy0), .done(done0)
  );

  led_blink_driver #(.ON_CYCLES(ON_C), .OFF_CYCLES(OFF_C), .COUNT_W(COUNT_W), .RETRIGGER(1)) dut1 (
    .clk(clk), .rst(rst), .trigger(trigger1), .blink_count(blink_count), .cancel(cancel1),
    .led_out(led1), .busy(busy1), .done(done1)
  );

  always #5 clk = ~clk;

  logic [2:0] q0[$];
  logic [2:0] q1[$];
  int         tests = 0;
  int         fails = 0;
  string      tag = "reset";

  task automatic push(input bit m0, input bit m1, input logic [2:0] v);
    if (m0) q0.push_back(v);
    if (m1) q1.push_back(v);
  endtask

  // Expected outputs of an undisturbed n-blink sequence, starting the cycle after the accepted trigger.
  task automatic push_blinks(input bit m0, input bit m1, input int n);
    for (int b = 0; b < n; b++) begin
      for (int i = 0; i < ON_C; i++) push(m0, m1, 3'b110);
      if (b < n - 1) for (int i = 0; i < OFF_C; i++) push(m0, m1, 3'b010);
    end
    push(m0, m1, 3'b001);
  endtask

  task automatic check(input string dname, input logic [2:0] obs, input logic [2:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s/%s t=%0t observed led,busy,done=%b expected=%b", tag, dname, $time, obs, exp);
    end
  endtask

  task automatic tick(input logic trig, input logic [COUNT_W-1:0] cnt, input logic canc, input logic r);
    logic [2:0] e0, e1;
    trigger     = trig;
    blink_count = cnt;
    cancel      = canc;
    rst         = r;
    @(posedge clk);
    #1;
    e0 = (q0.size() > 0) ? q0.pop_front() : 3'b000;
    e1 = (q1.size() > 0) ? q1.pop_front() : 3'b000;
    check("dut0", {led0, busy0, done0}, e0);
    check("dut1", {led1, busy1, done1}, e1);
    trigger = 1'b0;
    cancel  = 1'b0;
    rst     = 1'b0;
  endtask

  task automatic run(input int k);
    for (int i = 0; i < k; i++) tick(1'b0, '0, 1'b0, 1'b0);
  endtask

  initial begin
    // Reset state
    tag = "reset";
    push(1, 1, 3'b000); tick(1'b0, '0, 1'b0, 1'b1);
    push(1, 1, 3'b000); tick(1'b1, 4'd3, 1'b0, 1'b1);
    run(2);

    // Single blink
    tag = "single";
    push_blinks(1, 1, 1);
    tick(1'b1, 4'd1, 1'b0, 1'b0);
    run(3 + 3);

    // Triple blink: 14 queued cycles including the done cycle
    tag = "triple";
    push_blinks(1, 1, 3);
    tick(1'b1, 4'd3, 1'b0, 1'b0);
    run(13 + 2);

    // Zero count is ignored
    tag = "zero_count";
    tick(1'b1, 4'd0, 1'b0, 1'b0);
    run(3);

    // Five blinks, reset during the second OFF phase
    tag = "reset_mid";
    for (int i = 0; i < 3; i++) push(1, 1, 3'b110);
    for (int i = 0; i < 2; i++) push(1, 1, 3'b010);
    for (int i = 0; i < 3; i++) push(1, 1, 3'b110);
    push(1, 1, 3'b010);
    tick(1'b1, 4'd5, 1'b0, 1'b0);
    run(8);
    push(1, 1, 3'b000);
    tick(1'b0, '0, 1'b0, 1'b1);
    run(4);

    // Cancel during the second ON cycle
    tag = "cancel_on";
    push(1, 1, 3'b110); tick(1'b1, 4'd2, 1'b0, 1'b0);
    push(1, 1, 3'b110); tick(1'b0, '0, 1'b0, 1'b0);
    push(1, 1, 3'b000); tick(1'b0, '0, 1'b1, 1'b0);
    run(3);

    // Cancel and trigger together in IDLE
    tag = "cancel_idle";
    push(1, 1, 3'b000); tick(1'b1, 4'd3, 1'b1, 1'b0);
    run(2);

    // Triggers while busy and at completion are ignored without restart
    tag = "ignore_retrig";
    en1 = 1'b0;
    push_blinks(1, 0, 2);
    tick(1'b1, 4'd2, 1'b0, 1'b0);
    tick(1'b0, '0, 1'b0, 1'b0);
    tick(1'b1, 4'd3, 1'b0, 1'b0);
    tick(1'b0, '0, 1'b0, 1'b0);
    tick(1'b1, 4'd3, 1'b0, 1'b0);
    tick(1'b0, '0, 1'b0, 1'b0);
    tick(1'b0, '0, 1'b0, 1'b0);
    tick(1'b1, 4'd3, 1'b0, 1'b0);
    tick(1'b1, 4'd3, 1'b0, 1'b0);
    run(3);

    // Restart during OFF with count 1 on the restart-enabled instance
    tag = "restart";
    en1 = 1'b1;
    push_blinks(1, 0, 2);
    for (int i = 0; i < 3; i++) push(0, 1, 3'b110);
    push(0, 1, 3'b010);
    for (int i = 0; i < 3; i++) push(0, 1, 3'b110);
    push(0, 1, 3'b001);
    tick(1'b1, 4'd2, 1'b0, 1'b0);
    run(3);
    tick(1'b1, 4'd1, 1'b0, 1'b0);
    run(4 + 3);

    // Zero-count trigger while busy does not restart
    tag = "restart_zero";
    push_blinks(1, 1, 1);
    tick(1'b1, 4'd1, 1'b0, 1'b0);
    tick(1'b1, 4'd0, 1'b0, 1'b0);
    run(2 + 2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
